ws2812b_frame_sequencer: RTL and testbench



---
 rtl/ws2812b_pkg.sv | 36 +++
 rtl/ws2812b_scale.sv | 31 +++
 rtl/ws2812b_frame_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_ws2812b_frame_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared constants and types for the ws2812b frame sequencer
//
// Purpose: register map, CTRL bit positions, FSM state encoding and the
// GRB pixel type shared by the sequencer top and its channel scaler.
// Ports: none (package).

package ws2812b_pkg;

  // Byte-peripheral register map
  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_INDEX  = 4'd1;
  localparam logic [3:0] REG_G      = 4'd2;
  localparam logic [3:0] REG_R      = 4'd3;
  localparam logic [3:0] REG_B      = 4'd4;
  localparam logic [3:0] REG_COUNT  = 4'd5;
  localparam logic [3:0] REG_BRIGHT = 4'd6;

  // CTRL write bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_REPEAT = 1;
  localparam int CTRL_ABORT  = 7;

  // Frame FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Pixel as sent to the serialiser: {G, R, B}
  typedef logic [23:0] grb_t;
  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

endpackage

// File: rtl/ws2812b_scale.sv
// rtl/ws2812b_scale.sv - combinational per-channel brightness scaler
//
// Purpose: scales each 8-bit channel of a GRB pixel by (bright+1)/256.
// Ports:
//   pixel  in  24  {G,R,B} pixel from the buffer
//   bright in  8   global brightness, FF = identity, 00 = black
//   scaled out 24  scaled {G,R,B} pixel

module ws2812b_scale
  import ws2812b_pkg::*;
(
  input  logic [23:0] pixel,
  input  logic [7:0]  bright,
  output logic [23:0] scaled
);

  logic [8:0] mult;

  // Using bright+1 lets FF pass the channel through unchanged.
  assign mult = {1'b0, bright} + 9'd1;

  // 8x9 product never exceeds 16 bits (255*256), so bits [15:8] are the result.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] m);
    return 8'((17'(c) * 17'(m)) >> 8);
  endfunction

  assign scaled[G_LSB +: 8] = scale_ch(pixel[G_LSB +: 8], mult);
  assign scaled[R_LSB +: 8] = scale_ch(pixel[R_LSB +: 8], mult);
  assign scaled[B_LSB +: 8] = scale_ch(pixel[B_LSB +: 8], mult);

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// rtl/ws2812b_frame_sequencer.sv - frame-level pixel sequencer for the ws2812b serialiser
//
// Purpose: holds a pixel buffer written through byte registers and streams
// COUNT brightness-scaled pixels to the serialiser, one-shot or repeating.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   address[3:0]      register address
//   data_write        one-cycle write strobe
//   data_in[7:0]      write data
//   data_out[7:0]     read data, combinational from address
//   px_data[23:0]     {G,R,B} pixel to serialiser
//   px_valid          one-cycle pixel offer
//   px_latch          qualifies px_valid, marks last pixel of frame
//   px_ready          serialiser idle/accepting
//   busy              frame in progress
//   frame_done        one-cycle pulse after last pixel handed off

module ws2812b_frame_sequencer
  import ws2812b_pkg::*;
#(
  parameter int NUM_LEDS = 16,
  parameter int IDX_W    = $clog2(NUM_LEDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  address,
  input  logic        data_write,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [23:0] px_data,
  output logic        px_valid,
  output logic        px_latch,
  input  logic        px_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_LEDS);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [7:0]       stage_g_q, stage_g_d;
  logic [7:0]       stage_r_q, stage_r_d;
  logic [7:0]       stage_b_q, stage_b_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       bright_q, bright_d;
  logic             done_q, done_d;
  logic             repeat_q, repeat_d;
  logic [23:0]      px_data_q, px_data_d;
  logic             px_valid_q, px_valid_d;
  logic             px_latch_q, px_latch_d;
  logic             frame_done_q, frame_done_d;

  grb_t             pix_buf [NUM_LEDS];
  logic             buf_we;
  grb_t             scaled;
  logic             last_px;
  logic [IDX_W-1:0] index_wr;

  ws2812b_scale u_scale (
    .pixel  (pix_buf[ptr_q]),
    .bright (bright_q),
    .scaled (scaled)
  );

  // Written as ">=" rather than "==" so a COUNT shrunk below ptr mid-frame
  // still ends the frame instead of letting ptr run past the buffer.
  assign last_px  = ({1'b0, ptr_q} + CNT_W'(1)) >= count_q;
  assign index_wr = IDX_W'({24'd0, data_in} % NUM_LEDS);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    index_d      = index_q;
    stage_g_d    = stage_g_q;
    stage_r_d    = stage_r_q;
    stage_b_d    = stage_b_q;
    count_d      = count_q;
    bright_d     = bright_q;
    done_d       = done_q;
    repeat_d     = repeat_q;
    px_data_d    = px_data_q;
    px_valid_d   = 1'b0;
    px_latch_d   = 1'b0;
    frame_done_d = 1'b0;
    buf_we       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        px_data_d = scaled;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (px_ready) begin
          px_valid_d = 1'b1;
          px_latch_d = last_px;
          state_d    = ST_ACK;
        end
      end
      ST_ACK: begin
        // Serialiser dropping ready is its acknowledgement of the pixel.
        if (!px_ready) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (px_ready) begin
          if (!last_px) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = ST_FETCH;
          end else begin
            frame_done_d = 1'b1;
            done_d       = 1'b1;
            ptr_d        = '0;
            state_d      = repeat_q ? ST_FETCH : ST_IDLE;
          end
        end
      end
      default: ;
    endcase

    if (data_write) begin
      case (address)
        REG_CTRL: begin
          if (data_in[CTRL_ABORT]) begin
            state_d      = ST_IDLE;
            px_valid_d   = 1'b0;
            px_latch_d   = 1'b0;
            frame_done_d = 1'b0;
            done_d       = done_q;
            repeat_d     = 1'b0;
          end else begin
            repeat_d = data_in[CTRL_REPEAT];
            if (data_in[CTRL_START] && state_q == ST_IDLE && count_q != '0) begin
              ptr_d   = '0;
              done_d  = 1'b0;
              state_d = ST_FETCH;
            end
          end
        end
        REG_INDEX: index_d = index_wr;
        REG_G:     stage_g_d = data_in;
        REG_R:     stage_r_d = data_in;
        REG_B: begin
          stage_b_d = data_in;
          buf_we    = 1'b1;
          index_d   = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
        end
        REG_COUNT: count_d = (32'(data_in) > 32'(NUM_LEDS)) ? MAX_CNT : CNT_W'(data_in);
        REG_BRIGHT: bright_d = data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      index_q      <= '0;
      stage_g_q    <= '0;
      stage_r_q    <= '0;
      stage_b_q    <= '0;
      count_q      <= MAX_CNT;
      bright_q     <= 8'hFF;
      done_q       <= 1'b0;
      repeat_q     <= 1'b0;
      px_data_q    <= '0;
      px_valid_q   <= 1'b0;
      px_latch_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      index_q      <= index_d;
      stage_g_q    <= stage_g_d;
      stage_r_q    <= stage_r_d;
      stage_b_q    <= stage_b_d;
      count_q      <= count_d;
      bright_q     <= bright_d;
      done_q       <= done_d;
      repeat_q     <= repeat_d;
      px_data_q    <= px_data_d;
      px_valid_q   <= px_valid_d;
      px_latch_q   <= px_latch_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffer has no reset; a commit in the same cycle as FETCH of that slot
  // lands after the read, so FETCH sees the old pixel.
  always_ff @(posedge clk) begin
    if (buf_we) pix_buf[index_q] <= {stage_g_q, stage_r_q, data_in};
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      REG_CTRL:   data_out = {6'b0, done_q, busy};
      REG_INDEX:  data_out = 8'(index_q);
      REG_G:      data_out = stage_g_q;
      REG_R:      data_out = stage_r_q;
      REG_B:      data_out = stage_b_q;
      REG_COUNT:  data_out = 8'(count_q);
      REG_BRIGHT: data_out = bright_q;
      default:    data_out = 8'h00;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign px_data    = px_data_q;
  assign px_valid   = px_valid_q;
  assign px_latch   = px_latch_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// tb/tb_ws2812b_frame_sequencer.sv - scoreboard bench for ws2812b_frame_sequencer

module tb_ws2812b_frame_sequencer;

  localparam int NUM_LEDS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  address = 4'd0;
  logic        data_write = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic [7:0]  data_out;
  logic [23:0] px_data;
  logic        px_valid;
  logic        px_latch;
  logic        px_ready;
  logic        busy;
  logic        frame_done;

  logic model_on = 1'b0;
  logic model_ready = 1'b1;
  logic man_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int fd_cnt = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_exp;

  assign px_ready = model_on ? model_ready : man_ready;

  always #5 clk = ~clk;

  ws2812b_frame_sequencer #(.NUM_LEDS(NUM_LEDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .px_latch   (px_latch),
    .px_ready   (px_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Serialiser model: ready drops 2 cycles after a pixel offer, returns 30 later.
  always begin
    @(negedge clk);
    if (model_on && px_valid) begin
      repeat (2) @(negedge clk);
      model_ready = 1'b0;
      repeat (30) @(negedge clk);
      model_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every pixel offer.
  always @(negedge clk) begin
    if (rst_n && frame_done) fd_cnt++;
    if (rst_n && px_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_px: got %h expected none", {px_latch, px_data});
      end else begin
        mon_exp = exp_q.pop_front();
        check("px_latch_data", {7'd0, px_latch, px_data}, {7'd0, mon_exp});
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string name);
    @(negedge clk);
    address = a;
    #1;
    check(name, data_out, e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int v0;
    int f0;
    int seen;
    int n;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    rd(4'd0, 8'h00, "rst_ctrl");
    rd(4'd5, 8'h10, "rst_count");
    rd(4'd6, 8'hFF, "rst_bright");
    rd(4'd1, 8'h00, "rst_index");
    check("rst_px_valid", px_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);

    // Two-pixel frame, identity brightness
    wr(4'd1, 8'h00);
    wr(4'd2, 8'h11); wr(4'd3, 8'h22); wr(4'd4, 8'h33);
    wr(4'd2, 8'h44); wr(4'd3, 8'h55); wr(4'd4, 8'h66);
    rd(4'd1, 8'h02, "index_after_two");
    rd(4'd4, 8'h66, "stage_b_readback");
    wr(4'd5, 8'h02);
    wr(4'd6, 8'hFF);
    model_on = 1'b1;
    exp_q.push_back({1'b0, 24'h112233});
    exp_q.push_back({1'b1, 24'h445566});
    f0 = fd_cnt;
    wr(4'd0, 8'h01);
    check("busy_after_start", busy, 1);
    wait_idle("frame2_timeout", 500);
    check("frame2_done_cnt", fd_cnt - f0, 1);
    rd(4'd0, 8'h02, "ctrl_done");
    check("frame2_drained", exp_q.size(), 0);

    // Brightness 7F on FF8001: FF*128>>8=7F, 80*128>>8=40, 01*128>>8=00
    wr(4'd1, 8'h00);
    wr(4'd2, 8'hFF); wr(4'd3, 8'h80); wr(4'd4, 8'h01);
    wr(4'd6, 8'h7F);
    wr(4'd5, 8'h01);
    exp_q.push_back({1'b1, 24'h7F4000});
    wr(4'd0, 8'h01);
    wait_idle("bright7f_timeout", 300);

    // Brightness 00 blanks every channel
    wr(4'd6, 8'h00);
    exp_q.push_back({1'b1, 24'h000000});
    wr(4'd0, 8'h01);
    wait_idle("bright00_timeout", 300);

    // Serialiser held not-ready: no offer until ready rises
    wr(4'd6, 8'hFF);
    model_on = 1'b0;
    man_ready = 1'b0;
    v0 = valid_cnt;
    f0 = fd_cnt;
    wr(4'd0, 8'h01);
    repeat (100) @(negedge clk);
    check("hold_no_valid", valid_cnt - v0, 0);
    check("hold_busy", busy, 1);
    exp_q.push_back({1'b1, 24'hFF8001});
    man_ready = 1'b1;
    repeat (5) @(negedge clk);
    man_ready = 1'b0;
    repeat (3) @(negedge clk);
    man_ready = 1'b1;
    wait_idle("hold_timeout", 50);
    check("hold_one_valid", valid_cnt - v0, 1);
    check("hold_frame_done", fd_cnt - f0, 1);

    // Repeat mode, then abort during ACK of the third pass
    model_on = 1'b1;
    repeat (3) exp_q.push_back({1'b1, 24'hFF8001});
    f0 = fd_cnt;
    wr(4'd0, 8'h03);
    seen = 0;
    n = 0;
    while (seen < 3 && n < 600) begin
      @(negedge clk);
      n++;
      if (px_valid) seen++;
    end
    check("repeat_three_offers", seen, 3);
    address = 4'd0;
    data_in = 8'h80;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    check("abort_idle_next", busy, 0);
    check("abort_no_valid", px_valid, 0);
    v0 = valid_cnt;
    repeat (100) @(negedge clk);
    check("abort_no_more_valid", valid_cnt - v0, 0);
    check("abort_stays_idle", busy, 0);
    check("repeat_frame_done_cnt", fd_cnt - f0, 2);
    rd(4'd0, 8'h02, "abort_done_kept");

    // Abort and start in one write: abort wins
    wr(4'd0, 8'h81);
    @(negedge clk);
    check("abort_start_idle", busy, 0);

    // Index wrap, index modulo, count clamp / zero, unmapped register
    wr(4'd1, 8'(NUM_LEDS - 1));
    wr(4'd2, 8'h01); wr(4'd3, 8'h02); wr(4'd4, 8'h03);
    rd(4'd1, 8'h00, "index_wrap");
    wr(4'd1, 8'h13);
    rd(4'd1, 8'h03, "index_mod");
    wr(4'd5, 8'h40);
    rd(4'd5, 8'h10, "count_clamp");
    wr(4'd5, 8'h00);
    rd(4'd5, 8'h00, "count_zero");
    wr(4'd0, 8'h01);
    repeat (3) @(negedge clk);
    check("count0_start_ignored", busy, 0);
    wr(4'd7, 8'h5A);
    rd(4'd7, 8'h00, "unmapped_read");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
